spi_slave_frame: RTL and testbench

Parametrised SPI slave frame engine for shifting out trigger/status words to an external SPI master. Asynchronous SCLK/CS/MOSI are oversampled on sampling_clk, and the block supports all four SPI modes, a configurable frame width and bit order. It adds mid-frame abort detection, overrun flagging and a frame counter. It replaces the fixed 128-bit MSB-first mode-3 shifter in the readout path.

---
 rtl/spi_slave_frame.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave frame engine. SCLK/CS/MOSI are oversampled on
// sampling_clk; all four SPI modes, any frame width and either bit order.
// Adds abort detection, a sticky overrun flag and a completed-frame counter.
// Optional receive path is compiled in with the macro SPI_SLAVE_RX_EN.
// Pulse outputs (tx_load, frame_done, aborted, rx_valid) are single-cycle
// strobes with no ready/back-pressure: the consumer must take them on sight.
module spi_slave_frame #(
  parameter int WIDTH       = 128,
  parameter int CPOL        = 1,
  parameter int CPHA        = 1,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sampling_clk,
  input  logic             rst,
  input  logic             sclk_async,
  input  logic             cs_async,
  input  logic             mosi_async,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_load,
  output logic             busy,
  output logic             frame_done,
  output logic             aborted,
  output logic             overrun,
  output logic [15:0]      frame_count,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);
  localparam int   BW     = $clog2(WIDTH + 1);
  localparam logic CPOL_L = (CPOL != 0);
  localparam logic CPHA_L = (CPHA != 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
  logic sclk_hist_q, cs_hist_q;
  logic sclk_s, cs_s;
  logic sclk_rise, sclk_fall, sclk_lead, sclk_trail;
  logic shift_edge, sample_edge, cs_fall, cs_rise, last_sample;

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift, tx_shift;
  logic             sr_out, tx_out;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic miso_q, miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
  logic overrun_q, overrun_d, tx_load_q, tx_load_d;
  logic frame_done_q, frame_done_d, aborted_q, aborted_d;
  // sampled_q: a sample edge has been seen this frame (CPHA=0 shift gating).
  // close_pend_q: CPHA=0 frames end with one trailing edge that is part of
  // the frame; it must not be mistaken for an overrun shift.
  logic sampled_q, sampled_d, close_pend_q, close_pend_d;

  // Input synchronisers plus history flop. CS resets low so that a CS
  // already low at reset release produces no falling edge.
  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL_L}};
      sclk_hist_q <= CPOL_L;
      cs_sync_q   <= '0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_async};
      sclk_hist_q <= sclk_s;
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_async};
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_hist_q;
  assign sclk_fall   = ~sclk_s & sclk_hist_q;
  assign sclk_lead   = CPOL_L ? sclk_fall : sclk_rise;
  assign sclk_trail  = CPOL_L ? sclk_rise : sclk_fall;
  assign shift_edge  = CPHA_L ? sclk_lead : sclk_trail;
  assign sample_edge = CPHA_L ? sclk_trail : sclk_lead;
  assign cs_fall     = ~cs_s & cs_hist_q;
  assign cs_rise     = cs_s & ~cs_hist_q;
  assign last_sample = sample_edge && (bcnt_q == BW'(WIDTH - 1));

  // Bit-order helpers: output bit and one-step shift toward the output end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sr_out   = sr_q[WIDTH-1];
      tx_out   = tx_data[WIDTH-1];
      sr_shift = {sr_q[WIDTH-2:0], 1'b0};
      tx_shift = {tx_data[WIDTH-2:0], 1'b0};
    end else begin
      sr_out   = sr_q[0];
      tx_out   = tx_data[0];
      sr_shift = {1'b0, sr_q[WIDTH-1:1]};
      tx_shift = {1'b0, tx_data[WIDTH-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge sampling_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cs_fall) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (last_sample)  state_d = cs_rise ? S_IDLE : S_DONE;
        else if (cs_rise) state_d = S_IDLE;
      end
      S_DONE:   if (cs_rise) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output / datapath next-state logic. For CPHA=0 the first bit is
  // presented at load time, so the register is loaded pre-shifted and every
  // later shift edge simply presents the current output bit.
  always_comb begin
    sr_d          = sr_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    busy_d        = busy_q;
    bcnt_d        = bcnt_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    sampled_d     = sampled_q;
    close_pend_d  = close_pend_q;
    tx_load_d     = 1'b0;
    frame_done_d  = 1'b0;
    aborted_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          sr_d         = CPHA_L ? tx_data : tx_shift;
          miso_d       = CPHA_L ? miso_q : tx_out;
          tx_load_d    = 1'b1;
          bcnt_d       = '0;
          overrun_d    = 1'b0;
          busy_d       = 1'b1;
          miso_oe_d    = 1'b1;
          sampled_d    = 1'b0;
          close_pend_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (shift_edge && (CPHA_L || sampled_q)) begin
          miso_d = sr_out;
          sr_d   = sr_shift;
        end
        if (sample_edge) begin
          sampled_d = 1'b1;
          bcnt_d    = (bcnt_q == BW'(WIDTH)) ? bcnt_q : bcnt_q + BW'(1);
        end
        if (last_sample) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          busy_d        = 1'b0;
          miso_d        = 1'b0;
          close_pend_d  = !CPHA_L;
          if (cs_rise) miso_oe_d = 1'b0;
        end else if (cs_rise) begin
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (shift_edge) begin
          if (close_pend_q) close_pend_d = 1'b0;
          else              overrun_d    = 1'b1;
        end
        if (cs_rise) miso_oe_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      sr_q          <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      bcnt_q        <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      sampled_q     <= 1'b0;
      close_pend_q  <= 1'b0;
      tx_load_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      busy_q        <= busy_d;
      bcnt_q        <= bcnt_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      sampled_q     <= sampled_d;
      close_pend_q  <= close_pend_d;
      tx_load_q     <= tx_load_d;
      frame_done_q  <= frame_done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;
  assign tx_load     = tx_load_q;
  assign frame_done  = frame_done_q;
  assign aborted     = aborted_q;

`ifdef SPI_SLAVE_RX_EN
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [WIDTH-1:0]       rx_sr_q, rx_data_q, rx_shift;
  logic                   rx_valid_q, mosi_s;

  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rx_shift = (MSB_FIRST != 0) ? {rx_sr_q[WIDTH-2:0], mosi_s}
                                     : {mosi_s, rx_sr_q[WIDTH-1:1]};

  // Receive path: shift MOSI in on sample edges, publish at frame completion.
  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_async};
      rx_valid_q  <= 1'b0;
      if (state_q == S_ACTIVE && sample_edge) begin
        rx_sr_q <= rx_shift;
        if (last_sample) begin
          rx_data_q  <= rx_shift;
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_mosi;
  assign unused_mosi = mosi_async;
  assign rx_data     = '0;
  assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: two instances (128-bit mode 3 MSB-first and
// 16-bit mode 0 LSB-first) driven by behavioural SPI masters.
`timescale 1ns/1ps
module tb_spi_slave_frame;
  localparam int WA = 128;
  localparam int WB = 16;
  localparam int H  = 4;   // SCLK half period in sampling_clk cycles
`ifdef SPI_SLAVE_RX_EN
  localparam bit RXEN = 1'b1;
`else
  localparam bit RXEN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic sclk_a, cs_a, mosi_a, miso_a, miso_oe_a, tx_load_a, busy_a;
  logic frame_done_a, aborted_a, overrun_a, rx_valid_a;
  logic [WA-1:0] tx_a, rx_data_a;
  logic [15:0]   frame_count_a;

  logic sclk_b, cs_b, mosi_b, miso_b, miso_oe_b, tx_load_b, busy_b;
  logic frame_done_b, aborted_b, overrun_b, rx_valid_b;
  logic [WB-1:0] tx_b, rx_data_b;
  logic [15:0]   frame_count_b;

  spi_slave_frame #(.WIDTH(WA), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut_a (
    .sampling_clk(clk), .rst(rst), .sclk_async(sclk_a), .cs_async(cs_a), .mosi_async(mosi_a),
    .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_a), .tx_load(tx_load_a), .busy(busy_a),
    .frame_done(frame_done_a), .aborted(aborted_a), .overrun(overrun_a),
    .frame_count(frame_count_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a));

  spi_slave_frame #(.WIDTH(WB), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut_b (
    .sampling_clk(clk), .rst(rst), .sclk_async(sclk_b), .cs_async(cs_b), .mosi_async(mosi_b),
    .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_b), .tx_load(tx_load_b), .busy(busy_b),
    .frame_done(frame_done_b), .aborted(aborted_b), .overrun(overrun_b),
    .frame_count(frame_count_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b));

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected frame_count / rx word per completed frame
  logic [15:0]   exp_cnt_a_q[$];
  logic [WA-1:0] exp_rx_a_q[$];
  logic [15:0]   exp_cnt_b_q[$];
  logic [WB-1:0] exp_rx_b_q[$];
  int cnt_a = 0, cnt_b = 0;          // model of completed frames
  int ld_exp_a = 0, ld_exp_b = 0, ab_exp_a = 0;
  int ld_seen_a = 0, ld_seen_b = 0, ab_seen_a = 0, ab_seen_b = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit i of a serial stream carrying word tx, w bits, in the given order;
  // anything past the end of the word reads as 0.
  function automatic logic model_bit(input logic [127:0] tx, input int w, input bit msb, input int i);
    if (i >= w) return 1'b0;
    return msb ? tx[w-1-i] : tx[i];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // monitor: pops the scoreboard whenever a DUT reports a completed frame
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done_a) begin
        if (exp_cnt_a_q.size() == 0) check("done_a_unexpected", 1, 0);
        else begin
          check("count_a", frame_count_a, exp_cnt_a_q.pop_front());
          check("rx_data_a", rx_data_a, exp_rx_a_q.pop_front());
          check("busy_at_done_a", busy_a, 0);
        end
      end
      if (frame_done_b) begin
        if (exp_cnt_b_q.size() == 0) check("done_b_unexpected", 1, 0);
        else begin
          check("count_b", frame_count_b, exp_cnt_b_q.pop_front());
          check("rx_data_b", rx_data_b, exp_rx_b_q.pop_front());
        end
      end
      if (frame_done_a || rx_valid_a) check("rx_valid_a", rx_valid_a, RXEN & frame_done_a);
      if (frame_done_b || rx_valid_b) check("rx_valid_b", rx_valid_b, RXEN & frame_done_b);
      if (tx_load_a) ld_seen_a++;
      if (tx_load_b) ld_seen_b++;
      if (aborted_a) ab_seen_a++;
      if (aborted_b) ab_seen_b++;
    end
  end

  // Mode-3 MSB-first master for instance A. abort_at / rst_at < 0 disable.
  task automatic xfer_a(input logic [WA-1:0] txw, input logic [WA-1:0] mw, input int nclk,
                        input int abort_at, input int rst_at, output logic [WA-1:0] got);
    got = '0;
    tx_a = txw;
    ld_exp_a++;
    cs_a = 1'b0;
    wait_cyc(H);
    check("ovr_clear_a", overrun_a, 0);
    for (int i = 0; i < nclk; i++) begin
      if (i == abort_at) break;
      sclk_a = 1'b0;
      mosi_a = model_bit(mw, WA, 1'b1, i);
      wait_cyc(H);
      if (i < WA) got[WA-1-i] = miso_a;
      else check("extra_bit_a", miso_a, 0);
      if (i == 1) tx_a = rnd128();
      if (i == 2 && rst_at != 0 && rst_at != 1) begin
        check("busy_mid_a", busy_a, 1);
        check("oe_mid_a", miso_oe_a, 1);
      end
      sclk_a = 1'b1;
      wait_cyc(H);
      if (i == rst_at) begin
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(1);
        check("rst_busy_a", busy_a, 0);
        check("rst_oe_a", miso_oe_a, 0);
        check("rst_miso_a", miso_a, 0);
        check("rst_count_a", frame_count_a, 0);
        cnt_a = 0;
        cnt_b = 0;
      end
    end
    if (abort_at < 0 && rst_at < 0) check("overrun_a", overrun_a, nclk > WA);
    cs_a = 1'b1;
    wait_cyc(2 * H);
  endtask

  // Mode-0 LSB-first master for instance B (full frames only).
  task automatic xfer_b(input logic [WB-1:0] txw, input logic [WB-1:0] mw, output logic [WB-1:0] got);
    got = '0;
    tx_b = txw;
    ld_exp_b++;
    mosi_b = model_bit(mw, WB, 1'b0, 0);
    cs_b = 1'b0;
    wait_cyc(H);
    for (int i = 0; i < WB; i++) begin
      got[i] = miso_b;
      sclk_b = 1'b1;
      wait_cyc(H);
      sclk_b = 1'b0;
      mosi_b = model_bit(mw, WB, 1'b0, i + 1);
      if (i == 1) tx_b = WB'($urandom);
      wait_cyc(H);
    end
    check("overrun_b", overrun_b, 0);
    cs_b = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic push_a(input logic [WA-1:0] mw);
    cnt_a++;
    exp_cnt_a_q.push_back(16'(cnt_a));
    exp_rx_a_q.push_back(RXEN ? mw : '0);
  endtask

  task automatic push_b(input logic [WB-1:0] mw);
    cnt_b++;
    exp_cnt_b_q.push_back(16'(cnt_b));
    exp_rx_b_q.push_back(RXEN ? mw : '0);
  endtask

  logic [WA-1:0] ta, ma, ga;
  logic [WB-1:0] tbw, mbw, gb;

  initial begin
    rst = 1'b1;
    cs_a = 1'b1; sclk_a = 1'b1; mosi_a = 1'b0; tx_a = '0;
    cs_b = 1'b0; sclk_b = 1'b0; mosi_b = 1'b0; tx_b = '0;  // CS low across reset release
    wait_cyc(5);
    check("reset_miso_a", miso_a, 0);
    check("reset_oe_a", miso_oe_a, 0);
    check("reset_busy_a", busy_a, 0);
    check("reset_done_a", frame_done_a, 0);
    check("reset_abort_a", aborted_a, 0);
    check("reset_ovr_a", overrun_a, 0);
    check("reset_count_a", frame_count_a, 0);
    check("reset_load_a", tx_load_a, 0);
    check("reset_rx_a", {rx_valid_a, rx_data_a}, 0);
    rst = 1'b0;
    wait_cyc(12);
    check("cs_low_at_release_b", {busy_b, miso_oe_b}, 0);
    cs_b = 1'b1;
    wait_cyc(8);

    // known word, exact frame
    ta = 128'h0123456789abcdef_0123456789abcdef;
    ma = rnd128();
    push_a(ma);
    xfer_a(ta, ma, WA, -1, -1, ga);
    check("word_known_a", ga, ta);
    check("count_after1_a", frame_count_a, 1);

    // three extra clocks -> overrun, sticky after CS rise
    ta = rnd128(); ma = rnd128();
    push_a(ma);
    xfer_a(ta, ma, WA + 3, -1, -1, ga);
    check("word_ovr_a", ga, ta);
    check("ovr_sticky_a", overrun_a, 1);
    check("oe_idle_a", miso_oe_a, 0);

    // abort after 10 bits, then a clean frame (its start clears overrun)
    ta = rnd128(); ma = rnd128();
    ab_exp_a++;
    xfer_a(ta, ma, WA, 10, -1, ga);
    check("abort_seen_a", ab_seen_a, ab_exp_a);
    check("abort_busy_a", busy_a, 0);
    check("abort_oe_a", miso_oe_a, 0);
    check("abort_count_a", frame_count_a, cnt_a);
    ta = rnd128(); ma = rnd128();
    push_a(ma);
    xfer_a(ta, ma, WA, -1, -1, ga);
    check("word_after_abort_a", ga, ta);

    // reset pulse at bit 20, remaining clocks ignored, then clean frame
    ta = rnd128(); ma = rnd128();
    xfer_a(ta, ma, WA, -1, 20, ga);
    check("post_rst_busy_a", busy_a, 0);
    check("post_rst_count_a", frame_count_a, 0);
    ta = rnd128(); ma = rnd128();
    push_a(ma);
    xfer_a(ta, ma, WA, -1, -1, ga);
    check("word_after_rst_a", ga, ta);

    // mode 0 LSB-first known word, then random frames
    tbw = 16'hA5C3; mbw = WB'($urandom);
    push_b(mbw);
    xfer_b(tbw, mbw, gb);
    check("word_known_b", gb, tbw);
    for (int k = 0; k < 8; k++) begin
      tbw = WB'($urandom); mbw = WB'($urandom);
      push_b(mbw);
      xfer_b(tbw, mbw, gb);
      check("word_rand_b", gb, tbw);
    end
    check("count_end_b", frame_count_b, cnt_b);

    wait_cyc(20);
    check("sb_empty_a", exp_cnt_a_q.size(), 0);
    check("sb_empty_b", exp_cnt_b_q.size(), 0);
    check("loads_a", ld_seen_a, ld_exp_a);
    check("loads_b", ld_seen_b, ld_exp_b);
    check("aborts_a", ab_seen_a, ab_exp_a);
    check("aborts_b", ab_seen_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
